core_fetch_s: RTL and testbench

CORE_FETCH_S -- requirements
Module: core_fetch_s

---
 rtl/core_pkg.sv | 31 +++
 rtl/core_fetch_s_if.sv | 21 ++
 rtl/core_fetch_buf.sv | 38 +++
 rtl/core_fetch_s.sv | 138 +++++++++++++
 tb/tb_core_fetch_s.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core fetch stage: FSM states, the NOP encoding,
// the default reset PC and the fetch/decode pipeline register layout.
package core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD,
    ST_DROP
  } fetch_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [31:0] inst;
    logic        nop;
  } fd_reg_t;

  // A bubble keeps the PC pair of the register it replaces.
  function automatic fd_reg_t make_bubble(input fd_reg_t cur);
    fd_reg_t r;
    r      = cur;
    r.inst = NOP_INST;
    r.nop  = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/core_fetch_s_if.sv
// Request/acknowledge bus between the fetch stage and the L1 instruction cache.
interface core_fetch_s_if;
  logic        il1_req_out;
  logic [31:0] il1_addr_out;
  logic        il1_ack_in;
  logic [31:0] il1_data_in;

  modport master (
    output il1_req_out,
    output il1_addr_out,
    input  il1_ack_in,
    input  il1_data_in
  );

  modport slave (
    input  il1_req_out,
    input  il1_addr_out,
    output il1_ack_in,
    output il1_data_in
  );
endinterface

// File: rtl/core_fetch_buf.sv
// One-entry hold buffer for an instruction word that arrived while decode was stalled.
module core_fetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] data_i,
  output logic        valid_o,
  output logic [31:0] data_o
);

  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  // NOTE: the payload has no reset; valid_q alone says whether it means anything.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/core_fetch_s.sv
// Instruction fetch stage: issues L1 requests, tracks the PC, and feeds the
// fetch/decode register with instructions or bubbles.
module core_fetch_s
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           if_enb,
  input  logic           if_kill,
  input  logic           if_redirect_in,
  input  logic [31:0]    if_redirect_pc_in,
  core_fetch_s_if.master il1,
  output logic [31:0]    if_pc_out_reg,
  output logic [31:0]    if_pc_4_out_reg,
  output logic [31:0]    if_inst_out_reg,
  output logic           if_nop_gen_out_reg,
  output logic           if_stall_out
);

  localparam fd_reg_t FD_RESET = '{pc: 32'h0, pc_4: 32'h0, inst: NOP_INST, nop: 1'b1};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  fd_reg_t      fd_q, fd_d;

  logic         buf_load, buf_clear, buf_valid;
  logic [31:0]  buf_data;

  core_fetch_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .data_i  (il1.il1_data_in),
    .valid_o (buf_valid),
    .data_o  (buf_data)
  );

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    fd_d      = fd_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_WAIT;
        if (if_redirect_in) begin
          pc_d   = if_redirect_pc_in;
          addr_d = if_redirect_pc_in;
        end
        if (if_enb) fd_d = make_bubble(fd_q);
      end

      ST_WAIT: begin
        if (il1.il1_ack_in) begin
          if (if_redirect_in) begin
            pc_d   = if_redirect_pc_in;
            addr_d = if_redirect_pc_in;
          end else begin
            pc_d   = pc_q + 32'd4;
            addr_d = addr_q + 32'd4;
            if (if_enb) begin
              fd_d = '{pc: pc_q, pc_4: pc_q + 32'd4, inst: il1.il1_data_in, nop: 1'b0};
            end else begin
              buf_load = 1'b1;
              state_d  = ST_HOLD;
            end
          end
        end else if (if_redirect_in) begin
          // Request is still in flight at addr_q; let it finish, then refetch.
          pc_d    = if_redirect_pc_in;
          state_d = ST_DROP;
        end else if (if_enb) begin
          fd_d = make_bubble(fd_q);
        end
      end

      ST_HOLD: begin
        if (if_redirect_in) begin
          buf_clear = 1'b1;
          pc_d      = if_redirect_pc_in;
          addr_d    = if_redirect_pc_in;
          state_d   = ST_WAIT;
        end else if (if_enb && buf_valid && !if_kill) begin
          // pc_q already points past the buffered word.
          fd_d      = '{pc: pc_q - 32'd4, pc_4: pc_q, inst: buf_data, nop: 1'b0};
          buf_clear = 1'b1;
          state_d   = ST_WAIT;
        end
      end

      ST_DROP: begin
        if (if_redirect_in) begin
          pc_d = if_redirect_pc_in;
        end else if (il1.il1_ack_in) begin
          addr_d  = pc_q;
          state_d = ST_WAIT;
        end
        if (if_enb) fd_d = make_bubble(fd_q);
      end

      default: state_d = ST_IDLE;
    endcase

    if (if_redirect_in || if_kill) fd_d = make_bubble(fd_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      fd_q    <= FD_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      fd_q    <= fd_d;
    end
  end

  assign il1.il1_req_out  = (state_q == ST_WAIT) || (state_q == ST_DROP);
  assign il1.il1_addr_out = addr_q;
  assign if_stall_out     = (state_q == ST_WAIT) && !il1.il1_ack_in;

  assign if_pc_out_reg      = fd_q.pc;
  assign if_pc_4_out_reg    = fd_q.pc_4;
  assign if_inst_out_reg    = fd_q.inst;
  assign if_nop_gen_out_reg = fd_q.nop;

endmodule

// File: tb/tb_core_fetch_s.sv
// Directed bench for core_fetch_s: a cycle table for the main scenarios plus
// a hand-written address wrap sequence on a second instance.
module tb_core_fetch_s;
  import core_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enb, kill, redir;
  logic [31:0] redir_pc;
  logic [31:0] pc_o, pc4_o, inst_o;
  logic        nop_o, stall_o;

  logic        rst_w;
  logic [31:0] w_pc, w_pc4, w_inst;
  logic        w_nop, w_stall;

  core_fetch_s_if bus ();
  core_fetch_s_if wbus ();

  core_fetch_s u_dut (
    .clk                (clk),
    .rst                (rst),
    .if_enb             (enb),
    .if_kill            (kill),
    .if_redirect_in     (redir),
    .if_redirect_pc_in  (redir_pc),
    .il1                (bus.master),
    .if_pc_out_reg      (pc_o),
    .if_pc_4_out_reg    (pc4_o),
    .if_inst_out_reg    (inst_o),
    .if_nop_gen_out_reg (nop_o),
    .if_stall_out       (stall_o)
  );

  core_fetch_s #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk                (clk),
    .rst                (rst_w),
    .if_enb             (1'b1),
    .if_kill            (1'b0),
    .if_redirect_in     (1'b0),
    .if_redirect_pc_in  (32'h0),
    .il1                (wbus.master),
    .if_pc_out_reg      (w_pc),
    .if_pc_4_out_reg    (w_pc4),
    .if_inst_out_reg    (w_inst),
    .if_nop_gen_out_reg (w_nop),
    .if_stall_out       (w_stall)
  );

  typedef struct {
    logic        rst, enb, kill, redir;
    logic [31:0] rpc;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic [31:0] pc, pc4, inst;
    logic        nop;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, e, k, rd, input logic [31:0] rp, input logic a,
                              input logic q, input logic [31:0] ad, input logic s,
                              input logic [31:0] p, p4, in, input logic n);
    vec_t v;
    v.rst = r; v.enb = e; v.kill = k; v.redir = rd; v.rpc = rp; v.ack = a;
    v.req = q; v.addr = ad; v.stall = s; v.pc = p; v.pc4 = p4; v.inst = in; v.nop = n;
    return v;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // rst  enb kill redir rpc     ack | req addr       stall | pc      pc4     inst           nop
    vecs[0]  = mk(0, 1, 0, 0, 32'h0,   1,  0, 32'h0,   0,  32'h0,   32'h0,   NOP_INST,      1);
    vecs[1]  = mk(0, 1, 0, 0, 32'h0,   1,  1, 32'h0,   0,  32'h0,   32'h4,   32'hC0DE_0000, 0);
    vecs[2]  = mk(0, 1, 0, 0, 32'h0,   1,  1, 32'h4,   0,  32'h4,   32'h8,   32'hC0DE_0004, 0);
    vecs[3]  = mk(0, 1, 0, 0, 32'h0,   0,  1, 32'h8,   1,  32'h4,   32'h8,   NOP_INST,      1);
    vecs[4]  = mk(0, 1, 0, 0, 32'h0,   0,  1, 32'h8,   1,  32'h4,   32'h8,   NOP_INST,      1);
    vecs[5]  = mk(0, 1, 0, 0, 32'h0,   0,  1, 32'h8,   1,  32'h4,   32'h8,   NOP_INST,      1);
    vecs[6]  = mk(0, 1, 0, 0, 32'h0,   1,  1, 32'h8,   0,  32'h8,   32'hC,   32'hC0DE_0008, 0);
    vecs[7]  = mk(0, 0, 0, 0, 32'h0,   1,  1, 32'hC,   0,  32'h8,   32'hC,   32'hC0DE_0008, 0);
    vecs[8]  = mk(0, 0, 0, 0, 32'h0,   0,  0, 32'h10,  0,  32'h8,   32'hC,   32'hC0DE_0008, 0);
    vecs[9]  = mk(0, 1, 0, 0, 32'h0,   0,  0, 32'h10,  0,  32'hC,   32'h10,  32'hC0DE_000C, 0);
    vecs[10] = mk(0, 1, 0, 1, 32'h100, 0,  1, 32'h10,  1,  32'hC,   32'h10,  NOP_INST,      1);
    vecs[11] = mk(0, 1, 0, 0, 32'h0,   0,  1, 32'h10,  0,  32'hC,   32'h10,  NOP_INST,      1);
    vecs[12] = mk(0, 1, 0, 0, 32'h0,   1,  1, 32'h10,  0,  32'hC,   32'h10,  NOP_INST,      1);
    vecs[13] = mk(0, 1, 0, 0, 32'h0,   1,  1, 32'h100, 0,  32'h100, 32'h104, 32'hC0DE_0100, 0);
    vecs[14] = mk(0, 1, 0, 1, 32'h20,  1,  1, 32'h104, 0,  32'h100, 32'h104, NOP_INST,      1);
    vecs[15] = mk(0, 1, 1, 0, 32'h0,   1,  1, 32'h20,  0,  32'h100, 32'h104, NOP_INST,      1);
    vecs[16] = mk(0, 1, 0, 0, 32'h0,   1,  1, 32'h24,  0,  32'h24,  32'h28,  32'hC0DE_0024, 0);
    vecs[17] = mk(0, 1, 0, 1, 32'h200, 0,  1, 32'h28,  1,  32'h24,  32'h28,  NOP_INST,      1);
    vecs[18] = mk(1, 1, 0, 0, 32'h0,   0,  1, 32'h28,  0,  32'h0,   32'h0,   NOP_INST,      1);
    vecs[19] = mk(0, 1, 0, 0, 32'h0,   1,  0, 32'h0,   0,  32'h0,   32'h0,   NOP_INST,      1);
    vecs[20] = mk(0, 1, 0, 0, 32'h0,   1,  1, 32'h0,   0,  32'h0,   32'h4,   32'hC0DE_0000, 0);
    vecs[21] = mk(0, 0, 0, 0, 32'h0,   1,  1, 32'h4,   0,  32'h0,   32'h4,   32'hC0DE_0000, 0);
    vecs[22] = mk(0, 0, 0, 1, 32'h300, 0,  0, 32'h8,   0,  32'h0,   32'h4,   NOP_INST,      1);
    vecs[23] = mk(0, 1, 0, 0, 32'h0,   1,  1, 32'h300, 0,  32'h300, 32'h304, 32'hC0DE_0300, 0);
    vecs[24] = mk(0, 0, 0, 0, 32'h0,   0,  1, 32'h304, 1,  32'h300, 32'h304, 32'hC0DE_0300, 0);
    vecs[25] = mk(0, 0, 1, 0, 32'h0,   0,  1, 32'h304, 1,  32'h300, 32'h304, NOP_INST,      1);

    rst = 1'b1; enb = 1'b1; kill = 1'b0; redir = 1'b0; redir_pc = 32'h0;
    bus.il1_ack_in = 1'b1; bus.il1_data_in = 32'hDEAD_BEEF;
    rst_w = 1'b1; wbus.il1_ack_in = 1'b1; wbus.il1_data_in = 32'h0;

    // Reset with ack held high: nothing may leak through.
    repeat (2) @(posedge clk);
    #1;
    check("reset pc",   pc_o,   32'h0);
    check("reset pc4",  pc4_o,  32'h0);
    check("reset inst", inst_o, NOP_INST);
    check("reset nop",  {31'h0, nop_o}, 32'h1);

    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].rst; enb = vecs[i].enb; kill = vecs[i].kill;
      redir = vecs[i].redir; redir_pc = vecs[i].rpc;
      bus.il1_ack_in  = vecs[i].ack;
      bus.il1_data_in = word_at(vecs[i].addr);
      #4;
      check($sformatf("v%0d req", i),   {31'h0, bus.il1_req_out}, {31'h0, vecs[i].req});
      check($sformatf("v%0d addr", i),  bus.il1_addr_out,         vecs[i].addr);
      check($sformatf("v%0d stall", i), {31'h0, stall_o},         {31'h0, vecs[i].stall});
      @(posedge clk);
      #1;
      check($sformatf("v%0d pc", i),   pc_o,           vecs[i].pc);
      check($sformatf("v%0d pc4", i),  pc4_o,          vecs[i].pc4);
      check($sformatf("v%0d inst", i), inst_o,         vecs[i].inst);
      check($sformatf("v%0d nop", i),  {31'h0, nop_o}, {31'h0, vecs[i].nop});
    end

    // Address wrap: fetch from 0xFFFF_FFFC then 0x0, with PC+4 wrapping to 0.
    rst_w = 1'b0;
    wbus.il1_data_in = 32'hC0DE_FFFC;
    #4;
    check("wrap idle req", {31'h0, wbus.il1_req_out}, 32'h0);
    @(posedge clk);
    #4;
    check("wrap req",       {31'h0, wbus.il1_req_out}, 32'h1);
    check("wrap first addr", wbus.il1_addr_out,        32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    check("wrap pc",        w_pc,              32'hFFFF_FFFC);
    check("wrap pc4",       w_pc4,             32'h0);
    check("wrap inst",      w_inst,            32'hC0DE_FFFC);
    check("wrap next addr", wbus.il1_addr_out, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
